// File: rtl/trvk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trvk_ctrl
// Brief    : Tag-revocation checker for capability loads. Each tagged load
//            queues a pending check; a small FSM reads the revocation bitmap
//            word for the capability base and pulses a clear-tag request for
//            the destination register when the granule is marked revoked.
// Revision : 1.0 - initial release
// ============================================================================
module trvk_ctrl #(
    parameter int unsigned FifoDepth = 4,
    parameter logic [31:0] HeapBase  = 32'h8000_0000,
    parameter logic [31:0] HeapSize  = 32'h0004_0000,
    parameter logic [31:0] RvkBase   = 32'h8004_0000,
    parameter int unsigned CHERIoTEn = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ld_valid_i,
    output logic        ld_ready_o,
    input  logic [4:0]  ld_rd_i,
    input  logic        ld_tag_i,
    input  logic [31:0] ld_base_i,
    input  logic [2:0]  snp_we_i,
    input  logic [4:0]  snp_waddr0_i,
    input  logic [4:0]  snp_waddr1_i,
    input  logic [4:0]  snp_waddr2_i,
    output logic        bm_req_o,
    output logic [31:0] bm_addr_o,
    input  logic        bm_gnt_i,
    input  logic        bm_rvalid_i,
    input  logic [31:0] bm_rdata_i,
    output logic        trvk_en_o,
    output logic        trvk_clrtag_o,
    output logic [4:0]  trvk_addr_o,
    output logic [2:0]  pending_o
);

    localparam int unsigned         c_PTR_W   = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
    localparam logic [c_PTR_W-1:0]  c_LAST    = c_PTR_W'(FifoDepth - 1);
    localparam logic [2:0]          c_FULL    = 3'(FifoDepth);
    localparam logic                c_CHERI   = (CHERIoTEn != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Pending-check storage: destination register, capability base, kill bit
    logic [4:0]           r_rd   [FifoDepth];
    logic [31:0]          r_base [FifoDepth];
    logic [FifoDepth-1:0] r_kill;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [2:0]           r_count;

    state_t               r_state;
    logic                 r_revoked;
    logic                 r_bm_req;
    logic [31:0]          r_bm_addr;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_new_hit;
    logic [FifoDepth-1:0] w_hit;
    logic [4:0]           w_head_rd;
    logic [31:0]          w_head_base;
    logic                 w_head_kill;
    logic [31:0]          w_off;
    logic                 w_in_range;
    logic [4:0]           w_bit;
    logic [31:0]          w_bm_addr;

    // True when any enabled non-load writeback targets register rd
    function automatic logic snp_hit(input logic [4:0] rd, input logic [2:0] we,
                                     input logic [4:0] a0, input logic [4:0] a1,
                                     input logic [4:0] a2);
        return (we[0] && (a0 == rd)) || (we[1] && (a1 == rd)) || (we[2] && (a2 == rd));
    endfunction

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PTR_W'(1);
    endfunction

    assign ld_ready_o = (r_count != c_FULL);
    assign w_push     = ld_valid_i && ld_ready_o && ld_tag_i && (ld_rd_i != 5'd0);
    assign w_pop      = (r_state == S_DONE);
    assign w_new_hit  = snp_hit(ld_rd_i, snp_we_i, snp_waddr0_i, snp_waddr1_i, snp_waddr2_i);

    // Snoop comparison against every stored destination register
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < FifoDepth; i++) begin
            w_hit[i] = snp_hit(r_rd[i], snp_we_i, snp_waddr0_i, snp_waddr1_i, snp_waddr2_i);
        end
    end

    // Head decode: the kill view includes overwrites happening this very cycle
    assign w_head_rd   = r_rd[r_rptr];
    assign w_head_base = r_base[r_rptr];
    assign w_head_kill = r_kill[r_rptr] | w_hit[r_rptr];
    assign w_off       = w_head_base - HeapBase;
    assign w_in_range  = (w_head_base >= HeapBase) && (w_off < HeapSize);
    assign w_bit       = w_off[7:3];
    assign w_bm_addr   = RvkBase + {6'd0, w_off[31:8], 2'b00};

    // Entry storage: write on enqueue, otherwise accumulate kills from snoops
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < FifoDepth; i++) begin
                r_rd[i]   <= '0;
                r_base[i] <= '0;
                r_kill[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < FifoDepth; i++) begin
                if (w_push && (r_wptr == c_PTR_W'(i))) begin
                    r_rd[i]   <= ld_rd_i;
                    r_base[i] <= ld_base_i;
                    r_kill[i] <= w_new_hit;
                end else if (w_hit[i]) begin
                    r_kill[i] <= 1'b1;
                end
            end
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptr_inc(r_rptr);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Check sequencer: one bitmap read in flight at most, address held in REQ
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= S_IDLE;
            r_revoked <= 1'b0;
            r_bm_req  <= 1'b0;
            r_bm_addr <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (r_count != 3'd0) begin
                        if (w_in_range && !w_head_kill) begin
                            r_state   <= S_REQ;
                            r_bm_req  <= 1'b1;
                            r_bm_addr <= w_bm_addr;
                        end else begin
                            r_state   <= S_DONE;
                            r_revoked <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (bm_gnt_i) begin
                        r_state  <= S_WAIT;
                        r_bm_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bm_rvalid_i) begin
                        r_state   <= S_DONE;
                        r_revoked <= bm_rdata_i[w_bit];
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_revoked <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bm_req_o      = r_bm_req;
    assign bm_addr_o     = r_bm_addr;
    assign pending_o     = r_count;
    assign trvk_en_o     = (r_state == S_DONE);
    assign trvk_addr_o   = trvk_en_o ? w_head_rd : 5'd0;
    assign trvk_clrtag_o = trvk_en_o && r_revoked && !w_head_kill && c_CHERI;

endmodule
`default_nettype wire

// File: tb/tb_trvk_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trvk_ctrl
// Brief    : Self-checking bench for trvk_ctrl with a queue-based reference
//            model, a bitmap memory responder and directed scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trvk_ctrl;

    localparam int unsigned FifoDepth = 4;
    localparam logic [31:0] HeapBase  = 32'h8000_0000;
    localparam logic [31:0] HeapSize  = 32'h0004_0000;
    localparam logic [31:0] RvkBase   = 32'h8004_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        ld_valid_i = 1'b0;
    logic        ld_ready_o;
    logic [4:0]  ld_rd_i = '0;
    logic        ld_tag_i = 1'b0;
    logic [31:0] ld_base_i = '0;
    logic [2:0]  snp_we_i = '0;
    logic [4:0]  snp_waddr0_i = '0;
    logic [4:0]  snp_waddr1_i = '0;
    logic [4:0]  snp_waddr2_i = '0;
    logic        bm_req_o;
    logic [31:0] bm_addr_o;
    logic        bm_gnt_i = 1'b0;
    logic        bm_rvalid_i = 1'b0;
    logic [31:0] bm_rdata_i = '0;
    logic        trvk_en_o;
    logic        trvk_clrtag_o;
    logic [4:0]  trvk_addr_o;
    logic [2:0]  pending_o;

    trvk_ctrl #(
        .FifoDepth(FifoDepth), .HeapBase(HeapBase), .HeapSize(HeapSize),
        .RvkBase(RvkBase), .CHERIoTEn(1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ld_valid_i(ld_valid_i), .ld_ready_o(ld_ready_o), .ld_rd_i(ld_rd_i),
        .ld_tag_i(ld_tag_i), .ld_base_i(ld_base_i),
        .snp_we_i(snp_we_i), .snp_waddr0_i(snp_waddr0_i),
        .snp_waddr1_i(snp_waddr1_i), .snp_waddr2_i(snp_waddr2_i),
        .bm_req_o(bm_req_o), .bm_addr_o(bm_addr_o), .bm_gnt_i(bm_gnt_i),
        .bm_rvalid_i(bm_rvalid_i), .bm_rdata_i(bm_rdata_i),
        .trvk_en_o(trvk_en_o), .trvk_clrtag_o(trvk_clrtag_o),
        .trvk_addr_o(trvk_addr_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] base;
        logic        kill;
    } ent_t;

    int          errors = 0;
    int          checks = 0;
    ent_t        q[$];
    logic [31:0] bmap [16];
    logic [4:0]  done_q[$];
    int          n_done = 0;
    int          n_req = 0;
    logic [4:0]  last_addr = '0;
    logic        last_clr = 1'b0;
    logic [31:0] last_bm_addr = '0;
    bit          outstanding = 1'b0;
    logic [31:0] out_addr = '0;
    int          rv_cnt = 0;
    int          rv_min = 0;
    int          rv_max = 0;
    int          gnt_pct = 100;
    int          spur_pct = 0;
    bit          rsp_auto = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    function automatic logic in_range(input logic [31:0] base);
        return (base >= HeapBase) && ((base - HeapBase) < HeapSize);
    endfunction

    function automatic logic hit(input logic [4:0] rd);
        return (snp_we_i[0] && snp_waddr0_i == rd) || (snp_we_i[1] && snp_waddr1_i == rd) ||
               (snp_we_i[2] && snp_waddr2_i == rd);
    endfunction

    // Revoked iff in the heap, never overwritten, and its granule bit is set
    function automatic logic exp_clr(input ent_t e, input logic hitnow);
        logic [31:0] off;
        logic [31:0] w;
        off = e.base - HeapBase;
        if (!in_range(e.base) || e.kill || hitnow) return 1'b0;
        w = bmap[off[11:8]];
        return w[off[7:3]];
    endfunction

    // Compare process: DUT outputs vs model once per cycle, then advance model
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            q.delete();
            outstanding = 1'b0;
            check("rst_pending", 32'(pending_o), 0);
            check("rst_ready", 32'(ld_ready_o), 1);
            check("rst_outputs", {trvk_en_o, trvk_clrtag_o, trvk_addr_o, bm_req_o}, 0);
            check("rst_bm_addr", bm_addr_o, 0);
        end else begin
            int  sz;
            bit  acc;
            ent_t h;
            logic [31:0] off;
            sz = q.size();
            check("pending", 32'(pending_o), sz);
            check("ld_ready", 32'(ld_ready_o), 32'(sz != FifoDepth));
            if (!trvk_en_o) check("idle_outputs", {trvk_clrtag_o, trvk_addr_o}, 0);
            if (sz == 0) begin
                check("en_when_empty", 32'(trvk_en_o), 0);
                check("req_when_empty", 32'(bm_req_o), 0);
            end else begin
                h = q[0];
                if (trvk_en_o) begin
                    check("trvk_addr", 32'(trvk_addr_o), 32'(h.rd));
                    check("trvk_clrtag", 32'(trvk_clrtag_o), 32'(exp_clr(h, hit(h.rd))));
                    n_done++;
                    last_addr = trvk_addr_o;
                    last_clr  = trvk_clrtag_o;
                    done_q.push_back(trvk_addr_o);
                end
                if (!in_range(h.base)) check("req_out_of_range", 32'(bm_req_o), 0);
                if (bm_req_o) begin
                    off = h.base - HeapBase;
                    check("bm_addr", bm_addr_o, RvkBase + {6'd0, off[31:8], 2'b00});
                    if (bm_gnt_i) begin
                        outstanding  = 1'b1;
                        out_addr     = bm_addr_o;
                        last_bm_addr = bm_addr_o;
                        rv_cnt       = $urandom_range(rv_max, rv_min);
                        n_req++;
                    end
                end
            end
            acc = ld_valid_i && (sz != FifoDepth) && ld_tag_i && (ld_rd_i != 0);
            for (int i = 0; i < q.size(); i++) if (hit(q[i].rd)) q[i].kill = 1'b1;
            if (trvk_en_o && sz != 0) void'(q.pop_front());
            if (acc) q.push_back('{ld_rd_i, ld_base_i, hit(ld_rd_i)});
        end
    end

    // One clock step; the bitmap memory answers granted reads after a delay
    task automatic tick();
        @(posedge clk_i);
        #1;
        if (rsp_auto) begin
            bm_gnt_i = ($urandom_range(99) < gnt_pct);
            if (outstanding && rv_cnt == 0) begin
                bm_rvalid_i = 1'b1;
                bm_rdata_i  = bmap[out_addr[5:2]];
                outstanding = 1'b0;
            end else begin
                if (outstanding) rv_cnt--;
                bm_rvalid_i = !outstanding && ($urandom_range(99) < spur_pct);
                bm_rdata_i  = $urandom;
            end
        end
    endtask

    task automatic load(input logic [4:0] rd, input logic [31:0] base, input logic tag);
        ld_valid_i = 1'b1;
        ld_rd_i    = rd;
        ld_base_i  = base;
        ld_tag_i   = tag;
        tick();
        ld_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] rand_base();
        case ($urandom_range(9))
            0:       return 32'h2000_0000 + 32'($urandom_range(4095));
            1:       return HeapBase - 32'd8;
            2:       return HeapBase + HeapSize;
            3:       return HeapBase + HeapSize - 32'd8;
            default: return HeapBase + 32'($urandom_range(4095));
        endcase
    endfunction

    initial begin
        int d0;
        int r0;
        int k;
        for (int i = 0; i < 16; i++) bmap[i] = '0;
        repeat (3) tick();
        rst_ni = 1'b1;
        tick();

        // Revoked hit: granule bit 5 of bitmap word 1
        bmap[1] = 32'h0000_0020;
        d0 = n_done; r0 = n_req;
        load(5'd9, 32'h8000_0128, 1'b1);
        repeat (8) tick();
        check("hit_done", n_done - d0, 1);
        check("hit_req", n_req - r0, 1);
        check("hit_bm_addr", last_bm_addr, 32'h8004_0004);
        check("hit_clrtag", 32'(last_clr), 1);
        check("hit_addr", 32'(last_addr), 9);

        // Same base, bit 5 clear
        bmap[1] = 32'hFFFF_FFDF;
        d0 = n_done;
        load(5'd9, 32'h8000_0128, 1'b1);
        repeat (8) tick();
        check("miss_done", n_done - d0, 1);
        check("miss_clrtag", 32'(last_clr), 0);

        // Out of range: completion without memory read
        d0 = n_done; r0 = n_req;
        load(5'd3, 32'h2000_0000, 1'b1);
        repeat (6) tick();
        check("oor_done", n_done - d0, 1);
        check("oor_req", n_req - r0, 0);
        check("oor_clrtag", 32'(last_clr), 0);
        check("oor_addr", 32'(last_addr), 3);

        // Untagged load and rd=0 produce nothing
        d0 = n_done; r0 = n_req;
        load(5'd4, 32'h8000_0128, 1'b0);
        load(5'd0, 32'h8000_0128, 1'b1);
        repeat (6) tick();
        check("filter_done", n_done - d0, 0);
        check("filter_req", n_req - r0, 0);

        // Overwrite of rd=5 while the read is in flight cancels the clear
        bmap[0] = 32'h0000_0100;
        rv_min = 3; rv_max = 3;
        d0 = n_done;
        load(5'd5, HeapBase + 32'h40, 1'b1);
        k = 0;
        while (!outstanding && k < 20) begin tick(); k++; end
        if (!outstanding) timeout("kill_wait_grant");
        snp_we_i = 3'b010; snp_waddr1_i = 5'd5;
        tick();
        snp_we_i = 3'b000; snp_waddr1_i = 5'd0;
        repeat (8) tick();
        check("kill_done", n_done - d0, 1);
        check("kill_clrtag", 32'(last_clr), 0);
        check("kill_addr", 32'(last_addr), 5);

        // Full: no grants, five back-to-back loads, four accepted
        gnt_pct = 0; rv_min = 0; rv_max = 2;
        done_q.delete();
        d0 = n_done;
        ld_valid_i = 1'b1; ld_tag_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            ld_rd_i = 5'(i);
            ld_base_i = HeapBase + 32'(i * 8);
            tick();
        end
        ld_valid_i = 1'b0;
        check("full_pending", 32'(pending_o), 4);
        check("full_ready", 32'(ld_ready_o), 0);
        gnt_pct = 100;
        k = 0;
        while (n_done - d0 < 4 && k < 200) begin tick(); k++; end
        if (n_done - d0 < 4) timeout("full_drain");
        repeat (4) tick();
        check("full_count", done_q.size(), 4);
        for (int i = 0; i < 4 && i < done_q.size(); i++) check("full_order", 32'(done_q[i]), i + 1);
        check("full_empty", 32'(pending_o), 0);

        // Reset while waiting for read data; the late data must be ignored
        rv_min = 20; rv_max = 20;
        d0 = n_done;
        load(5'd7, HeapBase + 32'h80, 1'b1);
        k = 0;
        while (!outstanding && k < 20) begin tick(); k++; end
        if (!outstanding) timeout("rst_wait_grant");
        tick();
        rsp_auto = 1'b0;
        bm_gnt_i = 1'b0;
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        bm_rvalid_i = 1'b1; bm_rdata_i = 32'hFFFF_FFFF;
        repeat (2) tick();
        bm_rvalid_i = 1'b0;
        repeat (4) tick();
        check("rst_abandon_done", n_done - d0, 0);
        check("rst_abandon_pending", 32'(pending_o), 0);
        rsp_auto = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 16; i++) bmap[i] = $urandom;
        gnt_pct = 60; spur_pct = 10; rv_min = 0; rv_max = 3;
        for (int c = 0; c < 3000; c++) begin
            ld_valid_i = ($urandom_range(99) < 50);
            ld_tag_i   = ($urandom_range(99) < 80);
            ld_rd_i    = 5'($urandom_range(7));
            ld_base_i  = rand_base();
            snp_we_i   = ($urandom_range(99) < 25) ? 3'($urandom) : 3'b000;
            snp_waddr0_i = 5'($urandom_range(7));
            snp_waddr1_i = 5'($urandom_range(7));
            snp_waddr2_i = 5'($urandom_range(7));
            tick();
        end
        ld_valid_i = 1'b0; snp_we_i = 3'b000;
        gnt_pct = 100;
        k = 0;
        while (q.size() != 0 && k < 200) begin tick(); k++; end
        if (q.size() != 0) timeout("random_drain");
        repeat (3) tick();
        check("random_final_pending", 32'(pending_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/trvk_ctrl.md
TRVK_CTRL -- requirements
Module: trvk_ctrl

Interface
REQ-001 Parameters SHALL be:
- FifoDepth, default 4: pending-check entries.
- HeapBase, default 32'h8000_0000: revocable heap start.
- HeapSize, default 32'h0004_0000: heap bytes.
- RvkBase, default 32'h8004_0000: revocation bitmap byte address.
- CHERIoTEn, default 1: 0 forces trvk_clrtag_o low.

REQ-002 Ports SHALL be:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ld_valid_i  in  1  capability load writeback
- ld_ready_o  out  1  entry accepted
- ld_rd_i  in  5  destination register
- ld_tag_i  in  1  loaded tag
- ld_base_i  in  32  capability base address
- snp_we_i  in  3  non-load regfile write enables
- snp_waddr0_i, snp_waddr1_i, snp_waddr2_i  in  5 each  snooped write addresses
- bm_req_o  out  1  bitmap read request
- bm_addr_o  out  32  word-aligned bitmap address
- bm_gnt_i  in  1  request granted
- bm_rvalid_i  in  1  read data valid
- bm_rdata_i  in  32  bitmap word
- trvk_en_o  out  1  check-complete pulse
- trvk_clrtag_o  out  1  clear tag of trvk_addr_o
- trvk_addr_o  out  5  target register
- pending_o  out  3  occupied entries

Function
REQ-003 Enqueue SHALL occur when ld_valid_i & ld_ready_o & ld_tag_i & (ld_rd_i!=0); otherwise the handshake completes with no entry.
REQ-004 ld_ready_o SHALL equal (pending_o != FifoDepth), combinationally.
REQ-005 Each entry SHALL hold rd, base and a kill bit; the FIFO SHALL be in-order with pointers wrapping modulo FifoDepth.
REQ-006 Any snp_we_i[k] with a matching snp_waddrk_i SHALL set the kill bit of every stored entry with equal rd, and of an entry enqueued in the same cycle.
REQ-007 The load's own writeback SHALL NOT appear on snp_*.
REQ-008 Offset SHALL be ld_base - HeapBase (32-bit); the entry is in range iff base >= HeapBase and offset < HeapSize.
REQ-009 bm_addr_o SHALL equal RvkBase + {offset[31:8], 2'b00}.
REQ-010 The bit index SHALL be offset[7:3] (one bit per 8 bytes).
REQ-011 FSM states SHALL be IDLE, REQ, WAIT, DONE, with one bitmap read outstanding at most.
REQ-012 IDLE: if the FIFO is non-empty and the head is in range and not killed, go to REQ; otherwise go to DONE with revoked=0.
REQ-013 REQ: assert bm_req_o with bm_addr_o held stable until bm_gnt_i; on grant go to WAIT.
REQ-014 WAIT: on bm_rvalid_i, latch revoked = bm_rdata_i[bit] and go to DONE; bm_rvalid_i in any other state SHALL be ignored.
REQ-015 DONE: for one cycle, trvk_en_o=1, trvk_addr_o=head rd, trvk_clrtag_o = revoked & ~kill & CHERIoTEn (kill sampled this cycle, including same-cycle snoops).
REQ-016 DONE: pop the head and return to IDLE.
REQ-017 Throughput SHALL be one completion per 2 cycles minimum for entries that need no memory read.
REQ-018 A completion SHALL occur ≥1 cycle after the request's entry is enqueued.
REQ-019 Simultaneous enqueue and pop SHALL leave pending_o unchanged.
REQ-020 When full, ld_valid_i SHALL be back-pressured; no entry SHALL be lost or overwritten.
REQ-021 trvk_clrtag_o and trvk_addr_o SHALL be 0 whenever trvk_en_o=0.

Reset
REQ-022 While rst_ni=0, the FIFO SHALL be emptied, the FSM forced to IDLE, bm_req_o, trvk_en_o, trvk_clrtag_o, trvk_addr_o, bm_addr_o and pending_o all 0, and ld_ready_o 1.
REQ-023 Reset mid-transaction SHALL abandon the outstanding read; a later bm_rvalid_i SHALL be ignored.

Verification
REQ-024 Revoked hit: base=32'h8000_0128, rd=9, grant immediately, rdata=32'h0000_0020 -> bm_addr_o=32'h8004_0004, one-cycle pulse trvk_en_o=1, trvk_clrtag_o=1, trvk_addr_o=9.
REQ-025 Not revoked: same base, rdata=32'hFFFF_FFDF -> trvk_en_o=1, trvk_clrtag_o=0.
REQ-026 Filter: base=32'h2000_0000, or tag=0, or rd=0 -> no bm_req_o; out-of-range gives pulse with clrtag=0, tag=0/rd=0 gives no pulse.
REQ-027 Kill: enqueue rd=5 (revoked), snp_we_i=3'b010 with snp_waddr1_i=5 while in WAIT -> trvk_en_o=1, trvk_clrtag_o=0.
REQ-028 Full: 5 back-to-back loads with bm_gnt_i=0 -> ld_ready_o=0 after 4 accepted, pending_o=4; release grants -> 4 in-order completions.
REQ-029 Reset in WAIT, then bm_rvalid_i=1 -> no trvk_en_o, pending_o=0.
